lint_slave_mem: RTL and testbench
=================================

Name: lint_slave_mem

Overview:
- LINT target (responder) for the debug LINT master port.
- Accepts single-beat read/write requests, stores data in a local word-addressed memory, and returns a response after a programmable number of wait cycles.
- Used as the memory model and endpoint behind the debug LINT path.
- Allows one outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 32: byte-address width of lint_add_i.
- DATA_WIDTH, 64: data width; must be a multiple of 8 and a power of two.
- AUX_WIDTH, 6: width of the aux sideband, which is echoed in the response.
- MEM_DEPTH, 256: number of DATA_WIDTH words; must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to MEM_DEPTH*DATA_WIDTH/8.

Ports:
- clk_i, input, 1: clock; all logic is on the rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- lint_req_i, input, 1: request valid.
- lint_add_i, input, ADDR_WIDTH: byte address.
- lint_wen_i, input, 1: 0 = write, 1 = read.
- lint_wdata_i, input, DATA_WIDTH: write data.
- lint_be_i, input, DATA_WIDTH/8: byte enables for writes.
- lint_aux_i, input, AUX_WIDTH: request tag.
- latency_i, input, 4: number of wait cycles, sampled at grant.
- lint_gnt_o, output, 1: request accepted.
- lint_r_valid_o, output, 1: one-cycle response pulse.
- lint_r_rdata_o, output, DATA_WIDTH: read data.
- lint_r_opc_o, output, 1: 1 = error response.
- lint_r_aux_o, output, AUX_WIDTH: echoed lint_aux_i.

Behaviour:
- Clocking and reset:
  - One clock, clk_i. Reset rst_i is synchronous and active-high.
  - Reset values: state = IDLE, lint_r_valid_o = 0, lint_r_rdata_o = 0, lint_r_opc_o = 0, lint_r_aux_o = 0, wait counter = 0.
  - Memory contents are not reset.
- Grant:
  - lint_gnt_o = lint_req_i & (state == IDLE). It is combinational and never asserted in WAIT or RESP.
- Handshake:
  - A transaction is accepted in cycle T when lint_req_i & lint_gnt_o.
  - On acceptance, register wen, word index, aux, latency_i and the range-error flag.
  - The master must hold lint_req_i and all request fields until granted. The slave does not check this.
- Word index:
  - index = (lint_add_i - BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to log2(MEM_DEPTH) bits.
  - The low byte-offset bits of the address are ignored.
- Write:
  - Memory is updated at the clock edge that ends cycle T.
  - Only bytes with lint_be_i[k] = 1 are written. be = 0 writes nothing but still produces a response.
  - A write response leaves lint_r_rdata_o unchanged.
- Read:
  - The memory word is captured into lint_r_rdata_o on the edge that asserts lint_r_valid_o.
  - A read issued after a write to the same word returns the written data.
- State machine:
  - IDLE: on handshake, go to WAIT if latency_i != 0 (counter := latency_i - 1), otherwise go to RESP.
  - WAIT: decrement the counter; go to RESP when the counter is 0.
  - RESP: lint_r_valid_o = 1 for exactly one cycle, with lint_r_aux_o = registered aux and lint_r_opc_o = registered error flag. Then return to IDLE.
- Latency:
  - lint_r_valid_o is high in cycle T + 1 + L, where L is latency_i sampled at grant.
  - Changes to latency_i mid-transaction have no effect.
- Throughput:
  - The earliest next grant is the cycle after RESP, so the minimum period is 2 cycles at L = 0.
  - A request held high during WAIT or RESP is granted in the first IDLE cycle.
- Output hold:
  - lint_r_rdata_o, lint_r_aux_o and lint_r_opc_o hold their values after the valid pulse until the next response.
- Reset mid-operation:
  - Reset aborts any transaction in WAIT or RESP. No response is issued.
  - A write granted in the same cycle that rst_i is high is not performed.

Optional Feature:
- Macro: LINT_SLV_ERR_EN.
- Defined:
  - An address outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8) sets the error flag.
  - Errored writes do not modify memory.
  - Errored reads return lint_r_rdata_o = 0.
  - The response still arrives with normal latency and lint_r_opc_o = 1.
- Not defined:
  - No range check; the index wraps modulo MEM_DEPTH.
  - lint_r_opc_o is tied to 0.

Test Plan:
- Reset then write: rst_i high 2 cycles; check all outputs 0. Write add=0x10, wdata=0x1122334455667788, be=0xFF, aux=5, latency_i=0 -> gnt in T, r_valid in T+1, r_aux=5, r_opc=0.
- Read-back with latency: read add=0x10, latency_i=3 -> r_valid exactly in T+4, rdata=0x1122334455667788; gnt stays low through T+4.
- Partial byte enables: write add=0x10, wdata=0xAAAAAAAAAAAAAAAA, be=0x0F; then read -> rdata=0x11223344AAAAAAAA.
- Back-to-back: req held high with 3 reads, latency 0 -> grants in T, T+2, T+4; responses in T+1, T+3, T+5; aux values echoed in order.
- Range error (LINT_SLV_ERR_EN defined): write add = BASE_ADDR + MEM_DEPTH*8 -> r_opc=1 and memory unchanged; read same address -> rdata=0, r_opc=1. Without the macro, the same write wraps to word 0 and r_opc=0.
- Reset mid-operation: rst_i asserted during WAIT (latency_i=5) -> no r_valid pulse; gnt available in the first cycle after reset deasserts.

Source files
------------

// File: rtl/lint_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : lint_slave_mem
//  Purpose  : LINT responder used as the memory model behind the debug LINT
//             master port. Accepts single-beat read/write requests into a
//             local word-addressed memory. Each response is returned after a
//             programmable number of wait cycles. Only one transaction can be
//             outstanding at a time.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          in   clock, rising edge
//    rst_i          in   synchronous active-high reset
//    lint_req_i     in   request valid
//    lint_add_i     in   byte address
//    lint_wen_i     in   0 = write, 1 = read
//    lint_wdata_i   in   write data
//    lint_be_i      in   write byte enables
//    lint_aux_i     in   request tag, echoed in the response
//    latency_i      in   wait cycles, sampled at grant
//    lint_gnt_o     out  request accepted (combinational)
//    lint_r_valid_o out  one-cycle response pulse
//    lint_r_rdata_o out  read data, held until the next read response
//    lint_r_opc_o   out  1 = error response
//    lint_r_aux_o   out  echoed tag
// ----------------------------------------------------------------------------
//  Build option
//    LINT_SLV_ERR_EN : when defined, addresses outside the memory window give
//                      an error response. Errored writes are dropped and
//                      errored reads return zero. When the option is
//                      undefined, the index wraps modulo MEM_DEPTH and
//                      lint_r_opc_o is always 0.
// ============================================================================
module lint_slave_mem #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    AUX_WIDTH  = 6,
   parameter int                    MEM_DEPTH  = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    lint_req_i,
   input  logic [ADDR_WIDTH-1:0]   lint_add_i,
   input  logic                    lint_wen_i,
   input  logic [DATA_WIDTH-1:0]   lint_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] lint_be_i,
   input  logic [AUX_WIDTH-1:0]    lint_aux_i,
   input  logic [3:0]              latency_i,
   output logic                    lint_gnt_o,
   output logic                    lint_r_valid_o,
   output logic [DATA_WIDTH-1:0]   lint_r_rdata_o,
   output logic                    lint_r_opc_o,
   output logic [AUX_WIDTH-1:0]    lint_r_aux_o
);

   localparam int c_BYTES = DATA_WIDTH / 8;
   localparam int c_OFF_W = $clog2(c_BYTES);
   localparam int c_IDX_W = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                 r_state;
   logic [3:0]             r_cnt;
   logic                   r_wen;
   logic [c_IDX_W-1:0]     r_idx;
   logic [AUX_WIDTH-1:0]   r_aux;
   logic                   r_err;
   logic                   r_valid;
   logic [DATA_WIDTH-1:0]  r_rdata;
   logic                   r_opc;
   logic [AUX_WIDTH-1:0]   r_aux_o;
   logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0]  w_offset;
   logic [c_IDX_W-1:0]     w_index;
   logic                   w_err;
   logic                   w_gnt;
   logic                   w_hs;
   logic                   w_unused;

   // Offset relative to the window. The byte-lane bits are dropped and the
   // word index is truncated, so out-of-window addresses wrap by construction.
   assign w_offset = lint_add_i - BASE_ADDR;
   assign w_index  = w_offset[c_OFF_W +: c_IDX_W];

`ifdef LINT_SLV_ERR_EN
   // The subtraction wraps addresses below BASE_ADDR to large values, so one
   // test on the bits above the window catches both sides of the range.
   assign w_err = |(w_offset >> (c_OFF_W + c_IDX_W));
`else
   assign w_err = 1'b0;
`endif

   // Byte-lane and above-window offset bits are intentionally ignored.
   assign w_unused = ^w_offset;

   assign w_gnt = lint_req_i & (r_state == ST_IDLE);
   assign w_hs  = w_gnt;

   // Storage has no reset. A write granted while reset is high is dropped.
   always_ff @(posedge clk_i) begin
      if (w_hs && !lint_wen_i && !w_err && !rst_i) begin
         for (int k = 0; k < c_BYTES; k++) begin
            if (lint_be_i[k]) begin
               r_mem[w_index][k*8 +: 8] <= lint_wdata_i[k*8 +: 8];
            end
         end
      end
   end

   // Transaction sequencer. Response fields are loaded on the edge that
   // enters RESP, so the fields line up with the valid pulse. The fields then
   // hold until the next response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_wen   <= 1'b0;
         r_idx   <= '0;
         r_aux   <= '0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
         r_rdata <= '0;
         r_opc   <= 1'b0;
         r_aux_o <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_wen <= lint_wen_i;
                  r_idx <= w_index;
                  r_aux <= lint_aux_i;
                  r_err <= w_err;
                  if (latency_i != 4'd0) begin
                     r_cnt   <= latency_i - 4'd1;
                     r_state <= ST_WAIT;
                  end else begin
                     // Zero latency: respond straight from the live request.
                     r_state <= ST_RESP;
                     r_valid <= 1'b1;
                     r_aux_o <= lint_aux_i;
                     r_opc   <= w_err;
                     if (lint_wen_i) begin
                        r_rdata <= w_err ? '0 : r_mem[w_index];
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_RESP;
                  r_valid <= 1'b1;
                  r_aux_o <= r_aux;
                  r_opc   <= r_err;
                  if (r_wen) begin
                     r_rdata <= r_err ? '0 : r_mem[r_idx];
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign lint_gnt_o     = w_gnt;
   assign lint_r_valid_o = r_valid;
   assign lint_r_rdata_o = r_rdata;
   assign lint_r_opc_o   = r_opc;
   assign lint_r_aux_o   = r_aux_o;

endmodule
`default_nettype wire

// File: tb/tb_lint_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lint_slave_mem
//  Purpose  : Self-checking bench for lint_slave_mem. Contains a directed
//             vector table, hand sequences for pipelining and reset abort,
//             and a randomized phase against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lint_slave_mem;

`ifdef LINT_SLV_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        lint_req_i;
   logic [31:0] lint_add_i;
   logic        lint_wen_i;
   logic [63:0] lint_wdata_i;
   logic [7:0]  lint_be_i;
   logic [5:0]  lint_aux_i;
   logic [3:0]  latency_i;
   logic        lint_gnt_o;
   logic        lint_r_valid_o;
   logic [63:0] lint_r_rdata_o;
   logic        lint_r_opc_o;
   logic [5:0]  lint_r_aux_o;

   lint_slave_mem dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .lint_req_i     (lint_req_i),
      .lint_add_i     (lint_add_i),
      .lint_wen_i     (lint_wen_i),
      .lint_wdata_i   (lint_wdata_i),
      .lint_be_i      (lint_be_i),
      .lint_aux_i     (lint_aux_i),
      .latency_i      (latency_i),
      .lint_gnt_o     (lint_gnt_o),
      .lint_r_valid_o (lint_r_valid_o),
      .lint_r_rdata_o (lint_r_rdata_o),
      .lint_r_opc_o   (lint_r_opc_o),
      .lint_r_aux_o   (lint_r_aux_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic [5:0]  aux;
      logic [3:0]  lat;
      logic [63:0] exp_rdata;
      logic        exp_opc;
   } vec_t;

   vec_t vt [12];

   // Drive at posedge+1 and sample at posedge+2. Report the observed latency
   // (valid cycle - grant cycle - 1) and the response fields.
   task automatic do_txn(input vec_t v, output int lat_seen, output logic [63:0] rd,
                         output logic opc, output logic [5:0] raux);
      int t_gnt;
      lat_seen = -1; rd = '0; opc = 1'b0; raux = '0; t_gnt = -1;
      @(posedge clk_i); #1;
      lint_req_i = 1'b1; lint_wen_i = v.wen; lint_add_i = v.addr; lint_wdata_i = v.wdata;
      lint_be_i = v.be; lint_aux_i = v.aux; latency_i = v.lat;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (lint_gnt_o) begin
            t_gnt = cyc;
            break;
         end
         @(posedge clk_i); #1;
      end
      @(posedge clk_i); #1;
      lint_req_i = 1'b0;
      latency_i  = 4'(~v.lat);   // must not affect the transaction in flight
      if (t_gnt < 0) begin
         chk("gnt_timeout", 64'd0, 64'd1);
         return;
      end
      for (int i = 0; i < 20; i++) begin
         #1;
         if (lint_r_valid_o) begin
            lat_seen = cyc - t_gnt - 1;
            rd = lint_r_rdata_o; opc = lint_r_opc_o; raux = lint_r_aux_o;
            break;
         end
         @(posedge clk_i); #1;
      end
      if (lat_seen < 0) begin
         chk("valid_timeout", 64'd0, 64'd1);
         return;
      end
      @(posedge clk_i); #2;
      chk("pulse_width", 64'(lint_r_valid_o), 64'd0);
   endtask

   // Three reads presented back-to-back with req held high. Period is L+2.
   task automatic b2b(input int lat);
      logic [31:0] addrs [3];
      logic [63:0] dat   [3];
      int p, j;
      addrs[0] = 32'h10;  dat[0] = 64'h1122_3344_AAAA_AAAA;
      addrs[1] = 32'h7F8; dat[1] = 64'h0123_4567_89AB_CDEF;
      addrs[2] = 32'h20;  dat[2] = 64'h0F0F_0F0F_0F0F_0F0F;
      p = lat + 2;
      j = 0;
      for (int k = 0; k <= 3 * p + 1; k++) begin
         @(posedge clk_i); #1;
         lint_req_i = (j < 3); lint_wen_i = 1'b1; lint_add_i = addrs[j % 3];
         lint_aux_i = 6'(21 + j); latency_i = 4'(lat); lint_be_i = 8'h00;
         #1;
         chk($sformatf("b2b_L%0d_gnt_k%0d", lat, k), 64'(lint_gnt_o),
             64'((k % p == 0) && (k < 3 * p)));
         chk($sformatf("b2b_L%0d_valid_k%0d", lat, k), 64'(lint_r_valid_o),
             64'((k % p == lat + 1) && (k < 3 * p)));
         if ((k % p == lat + 1) && (k < 3 * p)) begin
            chk($sformatf("b2b_L%0d_aux_k%0d", lat, k), 64'(lint_r_aux_o), 64'(21 + k / p));
            chk($sformatf("b2b_L%0d_rdata_k%0d", lat, k), lint_r_rdata_o, dat[k / p]);
         end
         if (lint_gnt_o) j++;
      end
      lint_req_i = 1'b0;
   endtask

   // Reference model state for the random phase
   logic [63:0] m_mem [256];
   logic [7:0]  m_bv  [256];
   int          m_free, m_resp, w, idx;
   bit          m_busy, m_gprev, have, err, exp_g, exp_v, p_read;
   logic [63:0] e_rd, e_mask, p_rd, p_mask;
   logic        e_opc, p_opc;
   logic [5:0]  e_aux, p_aux;

   int          ls;
   logic [63:0] rd;
   logic        op;
   logic [5:0]  ax;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b1; lint_req_i = 1'b0; lint_add_i = '0; lint_wen_i = 1'b1;
      lint_wdata_i = '0; lint_be_i = '0; lint_aux_i = '0; latency_i = '0;

      vt[0]  = '{1'b0, 32'h10,  64'h1122_3344_5566_7788, 8'hFF, 6'd5,  4'd0,  64'h0, 1'b0};
      vt[1]  = '{1'b1, 32'h10,  64'h0,                   8'h00, 6'd7,  4'd3,  64'h1122_3344_5566_7788, 1'b0};
      vt[2]  = '{1'b0, 32'h10,  64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 6'd9,  4'd1,  64'h1122_3344_5566_7788, 1'b0};
      vt[3]  = '{1'b1, 32'h10,  64'h0,                   8'h00, 6'd42, 4'd0,  64'h1122_3344_AAAA_AAAA, 1'b0};
      vt[4]  = '{1'b0, 32'h17,  64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 6'd3,  4'd2,  64'h1122_3344_AAAA_AAAA, 1'b0};
      vt[5]  = '{1'b1, 32'h13,  64'h0,                   8'h00, 6'd63, 4'd15, 64'h1122_3344_AAAA_AAAA, 1'b0};
      vt[6]  = '{1'b0, 32'h7F8, 64'h0123_4567_89AB_CDEF, 8'hFF, 6'd1,  4'd0,  64'h1122_3344_AAAA_AAAA, 1'b0};
      vt[7]  = '{1'b1, 32'h7F8, 64'h0,                   8'h00, 6'd2,  4'd1,  64'h0123_4567_89AB_CDEF, 1'b0};
      vt[8]  = '{1'b0, 32'h0,   64'h5555_5555_5555_5555, 8'hFF, 6'd4,  4'd0,  64'h0123_4567_89AB_CDEF, 1'b0};
      vt[9]  = '{1'b0, 32'h800, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 6'd6,  4'd1,  64'h0123_4567_89AB_CDEF, ERR};
      vt[10] = '{1'b1, 32'h800, 64'h0,                   8'h00, 6'd8,  4'd0,
                 ERR ? 64'h0 : 64'hDEAD_BEEF_CAFE_F00D, ERR};
      vt[11] = '{1'b1, 32'h0,   64'h0,                   8'h00, 6'd10, 4'd2,
                 ERR ? 64'h5555_5555_5555_5555 : 64'hDEAD_BEEF_CAFE_F00D, 1'b0};

      // ---- reset state
      @(posedge clk_i); #1;
      @(posedge clk_i); #2;
      chk("rst_valid", 64'(lint_r_valid_o), 64'd0);
      chk("rst_rdata", lint_r_rdata_o, 64'd0);
      chk("rst_opc",   64'(lint_r_opc_o), 64'd0);
      chk("rst_aux",   64'(lint_r_aux_o), 64'd0);
      chk("rst_gnt",   64'(lint_gnt_o), 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // ---- directed vector table
      for (int i = 0; i < 12; i++) begin
         do_txn(vt[i], ls, rd, op, ax);
         chk($sformatf("v%0d_latency", i), 64'(ls), 64'(vt[i].lat));
         chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
         chk($sformatf("v%0d_opc", i), 64'(op), 64'(vt[i].exp_opc));
         chk($sformatf("v%0d_aux", i), 64'(ax), 64'(vt[i].aux));
      end

      // ---- reset during WAIT aborts the read; write granted under reset is dropped
      do_txn('{1'b0, 32'h20, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 6'd13, 4'd0, 64'h0, 1'b0}, ls, rd, op, ax);
      chk("pre_wr_latency", 64'(ls), 64'd0);
      @(posedge clk_i); #1;
      lint_req_i = 1'b1; lint_wen_i = 1'b1; lint_add_i = 32'h20; lint_aux_i = 6'd11; latency_i = 4'd5;
      #1; chk("rm_gnt_T", 64'(lint_gnt_o), 64'd1);
      @(posedge clk_i); #1;
      lint_req_i = 1'b0;
      #1; chk("rm_valid_T1", 64'(lint_r_valid_o), 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1; lint_req_i = 1'b1; lint_wen_i = 1'b0; lint_add_i = 32'h20;
      lint_wdata_i = 64'hBAD0_BAD0_BAD0_BAD0; lint_be_i = 8'hFF;
      #1; chk("rm_gnt_in_wait", 64'(lint_gnt_o), 64'd0);
      @(posedge clk_i); #2;
      chk("rm_valid_rst", 64'(lint_r_valid_o), 64'd0);
      chk("rm_rdata_rst", lint_r_rdata_o, 64'd0);
      chk("rm_gnt_rst",   64'(lint_gnt_o), 64'd1);
      @(posedge clk_i); #1;
      rst_i = 1'b0; lint_wen_i = 1'b1; lint_aux_i = 6'd12; latency_i = 4'd0;
      #1; chk("rm_gnt_after_rst", 64'(lint_gnt_o), 64'd1);
      @(posedge clk_i); #1;
      lint_req_i = 1'b0;
      #1;
      chk("rm_valid_new", 64'(lint_r_valid_o), 64'd1);
      chk("rm_rdata_new", lint_r_rdata_o, 64'h0F0F_0F0F_0F0F_0F0F);
      chk("rm_aux_new",   64'(lint_r_aux_o), 64'd12);
      chk("rm_opc_new",   64'(lint_r_opc_o), 64'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_i); #2;
         chk($sformatf("rm_no_valid_%0d", i), 64'(lint_r_valid_o), 64'd0);
      end

      // ---- back-to-back with req held high
      b2b(0);
      b2b(3);

      // ---- randomized phase against a transaction-level model
      for (int i = 0; i < 256; i++) begin
         m_bv[i] = 8'h00;
         m_mem[i] = 64'h0;
      end
      m_free = 0; m_resp = 0; m_busy = 1'b0; m_gprev = 1'b0; have = 1'b0;
      e_rd = '0; e_mask = '0; e_opc = 1'b0; e_aux = '0;
      p_rd = '0; p_mask = '0; p_opc = 1'b0; p_aux = '0; p_read = 1'b0;
      for (int c = 0; c < 800; c++) begin
         @(posedge clk_i); #1;
         if (m_gprev) lint_req_i = 1'b0;
         m_gprev = 1'b0;
         latency_i = 4'($urandom_range(0, 15));
         if (!lint_req_i && ($urandom_range(0, 2) == 0)) begin
            w = $urandom_range(64, 79);
            lint_req_i   = 1'b1;
            lint_wen_i   = 1'($urandom_range(0, 1));
            lint_add_i   = 32'(w * 8 + $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) lint_add_i = lint_add_i + 32'h800;
            lint_wdata_i = {$urandom, $urandom};
            lint_be_i    = 8'($urandom);
            lint_aux_i   = 6'($urandom);
         end
         #1;
         exp_g = lint_req_i && (cyc >= m_free);
         exp_v = m_busy && (cyc == m_resp);
         chk("rnd_gnt",   64'(lint_gnt_o), 64'(exp_g));
         chk("rnd_valid", 64'(lint_r_valid_o), 64'(exp_v));
         if (exp_v) begin
            m_busy = 1'b0;
            have   = 1'b1;
            e_aux  = p_aux;
            e_opc  = p_opc;
            if (p_read) begin
               e_rd   = p_rd;
               e_mask = p_mask;
            end
         end
         if (have) begin
            chk("rnd_aux", 64'(lint_r_aux_o), 64'(e_aux));
            chk("rnd_opc", 64'(lint_r_opc_o), 64'(e_opc));
            if (e_mask != 64'h0)
               chk("rnd_rdata", lint_r_rdata_o & e_mask, e_rd & e_mask);
         end
         if (exp_g) begin
            idx    = int'(lint_add_i >> 3) % 256;
            err    = ERR && (lint_add_i >= 32'h800);
            p_aux  = lint_aux_i;
            p_opc  = err;
            p_read = lint_wen_i;
            if (lint_wen_i) begin
               if (err) begin
                  p_rd = 64'h0; p_mask = '1;
               end else begin
                  p_rd = m_mem[idx];
                  for (int b = 0; b < 8; b++) p_mask[b*8 +: 8] = {8{m_bv[idx][b]}};
               end
            end else if (!err) begin
               for (int b = 0; b < 8; b++) begin
                  if (lint_be_i[b]) begin
                     m_mem[idx][b*8 +: 8] = lint_wdata_i[b*8 +: 8];
                     m_bv[idx][b] = 1'b1;
                  end
               end
            end
            m_busy  = 1'b1;
            m_resp  = cyc + 1 + int'(latency_i);
            m_free  = cyc + 2 + int'(latency_i);
            m_gprev = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
